y86_execute_stage: RTL
======================

Name: y86_execute_stage

Overview:
- Y86-64 pipeline execute stage; the initiator side of the ALU interface.
- Accepts decoded instructions from the D/E boundary and selects ALU operands and function per icode.
- Drives the combinational ALU, receives valE and carry, maintains the ZF/SF/OF condition-code register and evaluates Cnd for jXX/cmovXX.
- Registers results into the E/M pipeline register with a valid/ready handshake.

Parameters:
- W, 64, datapath width (ALU operands, valE, valA/valB/valC).
- STACK_STEP, 8, byte adjustment applied to rsp for call/ret/pushq/popq.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_valid  in  1  decode holds a valid instruction.
- d_ready  out  1  stage can accept; = ~e_valid | e_ready.
- d_stat  in  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- d_icode  in  4  instruction code.
- d_ifun  in  4  function code.
- d_valA  in  W  register operand A.
- d_valB  in  W  register operand B.
- d_valC  in  W  immediate/displacement.
- d_dstE  in  4  E destination register.
- d_dstM  in  4  M destination register.
- m_exc  in  1  memory/writeback stage holds an exception; suppresses CC writes.
- alu_a  out  W  ALU operand A (combinational from d_*).
- alu_b  out  W  ALU operand B.
- alu_fn  out  4  0 add, 1 sub (a-b), 2 and, 3 xor.
- alu_valE  in  W  ALU result.
- alu_car  in  1  ALU carry/borrow; informational, not stored in CC.
- e_valid  out  1  E/M register valid.
- e_ready  in  1  memory stage accepts.
- e_stat  out  2  registered status.
- e_icode  out  4  registered icode.
- e_cnd  out  1  registered condition result.
- e_valE  out  W  registered ALU result.
- e_valA  out  W  registered valA pass-through.
- e_dstE  out  4  registered dstE; 0xF (RNONE) when cmov is not taken.
- e_dstM  out  4  registered dstM.
- cc  out  3  {ZF,SF,OF}, the current condition-code register.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - e_valid=0; e_stat, e_icode, e_cnd, e_valE, e_valA = 0; e_dstE=e_dstM=0xF.
  - cc = {ZF=1, SF=0, OF=0}.
  - Reset mid-transfer drops the held instruction with no CC write.
- Handshake:
  - accept = d_valid & d_ready. On accept, all e_* load from the current cycle's d_*/alu_valE, and e_valid=1.
  - If e_valid & e_ready & ~d_valid, then e_valid goes to 0 and the other outputs hold.
  - If e_valid & ~e_ready, all e_* hold and d_ready=0.
  - Latency: 1 cycle from accept to e_valid.
- Operand select (icode: alu_a / alu_b / alu_fn):
  - 2 rrmovq/cmov: valA / 0 / add.
  - 3 irmovq: valC / 0 / add.
  - 4 rmmovq, 5 mrmovq: valC / valB / add.
  - 6 OPq: valB / valA / ifun. Operands are swapped so that subq yields valB-valA.
  - 8 call, A pushq: valB / -STACK_STEP / add.
  - 9 ret, B popq: valB / +STACK_STEP / add.
  - All other icodes: 0 / 0 / add.
- OPq with ifun>3:
  - Treated as illegal: e_stat=INS and no CC write.
  - alu_fn forced to 0 (the ALU defines only fns 0-3).
- CC update:
  - Occurs only on accept with icode=6, legal ifun, d_stat=AOK and m_exc=0.
  - ZF = (valE==0); SF = valE[W-1].
  - OF for add: a[W-1]==b[W-1] and valE[W-1]!=a[W-1].
  - OF for sub: a[W-1]!=b[W-1] and valE[W-1]!=a[W-1].
  - OF for and/xor: 0.
- Cnd uses the CC value before this cycle's update. Conditions by ifun:
  - 0 always 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: ~ZF.
  - 5 ge: ~(SF^OF).
  - 6 g: ~(SF^OF)&~ZF.
  - Other ifun on icode 2/7 gives Cnd=0 and e_stat=INS.
  - For icodes other than 2/7, e_cnd=0.
- cmov: icode 2 with Cnd=0 gives e_dstE=0xF.
- Back-to-back: an OPq accepted in cycle n writes CC at edge n; a jXX accepted at n+1 sees the new CC.
- A non-AOK d_stat passes through to e_stat unchanged and suppresses CC writes.

Decomposition:
- Package y86_pkg holds:
  - icode localparams (I_HALT..I_POPQ);
  - ALU fn codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR);
  - stat codes (S_AOK, S_HLT, S_ADR, S_INS);
  - RNONE=4'hF;
  - condition ifun codes.
- One sub-module, y86_cond_eval: combinational (cc, ifun) -> (cnd, illegal).
- The ALU stays external, wired via alu_* ports.

Test Plan:
- After reset, check cc=3'b100 and e_valid=0. Then addq with valA=1, valB=-1 -> alu_a=-1, alu_b=1, alu_fn=0; e_valE=0; cc={1,0,0}.
- subq with valA=1, valB=0x8000_0000_0000_0000 -> e_valE=0x7FFF_FFFF_FFFF_FFFF; cc={0,0,1}.
- subq with valA=5, valB=3 (cc becomes SF=1), then jl next cycle -> e_cnd=1. Follow with jge -> e_cnd=0.
- cmovne with ZF=1, valA=0x55, dstE=3 -> e_valE=0x55, e_cnd=0, e_dstE=0xF.
- pushq with valB=0x100 -> e_valE=0xF8. popq with valB=0x100 -> e_valE=0x108. cc unchanged in both cases.
- Hold e_ready=0 for 3 cycles with d_valid=1 -> d_ready=0, e_* stable, no CC change.
- OPq with ifun=7 -> e_stat=3 and no CC write.
- addq with m_exc=1 -> cc unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, ALU functions,
// status codes, condition ifuns and the condition-code register layout.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Illegal OPq functions map to add so the ALU never sees an undefined code.
  function automatic logic [3:0] opq_alu_fn(input logic [3:0] ifun);
    case (ifun)
      4'd0:    return ALU_ADD;
      4'd1:    return ALU_SUB;
      4'd2:    return ALU_AND;
      4'd3:    return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic opq_legal(input logic [3:0] ifun);
    return ifun <= ALU_XOR;
  endfunction

endpackage

// File: rtl/y86_execute_stage_if.sv
// Bus bundle between decode, the external ALU and the memory stage.
// The execute stage uses the slave view; its environment uses master.
interface y86_execute_stage_if #(
  parameter int W = 64
);
  logic         d_valid;
  logic         d_ready;
  logic [1:0]   d_stat;
  logic [3:0]   d_icode;
  logic [3:0]   d_ifun;
  logic [W-1:0] d_valA;
  logic [W-1:0] d_valB;
  logic [W-1:0] d_valC;
  logic [3:0]   d_dstE;
  logic [3:0]   d_dstM;
  logic         m_exc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fn;
  logic [W-1:0] alu_valE;
  logic         alu_car;
  logic         e_valid;
  logic         e_ready;
  logic [1:0]   e_stat;
  logic [3:0]   e_icode;
  logic         e_cnd;
  logic [W-1:0] e_valE;
  logic [W-1:0] e_valA;
  logic [3:0]   e_dstE;
  logic [3:0]   e_dstM;
  logic [2:0]   cc;

  modport slave (
    input  d_valid, d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, m_exc, alu_valE, alu_car, e_ready,
    output d_ready, alu_a, alu_b, alu_fn, e_valid, e_stat, e_icode,
           e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc
  );

  modport master (
    output d_valid, d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, m_exc, alu_valE, alu_car, e_ready,
    input  d_ready, alu_a, alu_b, alu_fn, e_valid, e_stat, e_icode,
           e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc
  );

endinterface

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from the current
// {ZF,SF,OF}; unknown condition codes report illegal with cnd=0.
module y86_cond_eval
  import y86_pkg::*;
(
  input  cc_t        i_cc,
  input  logic [3:0] i_ifun,
  output logic       o_cnd,
  output logic       o_illegal
);

  logic w_lt;
  assign w_lt = i_cc.sf ^ i_cc.of;

  always_comb begin
    o_cnd     = 1'b0;
    o_illegal = 1'b0;
    case (i_ifun)
      C_YES:   o_cnd = 1'b1;
      C_LE:    o_cnd = w_lt | i_cc.zf;
      C_L:     o_cnd = w_lt;
      C_E:     o_cnd = i_cc.zf;
      C_NE:    o_cnd = ~i_cc.zf;
      C_GE:    o_cnd = ~w_lt;
      C_G:     o_cnd = ~w_lt & ~i_cc.zf;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: drives the external ALU, owns the condition codes,
// evaluates Cnd and registers results into the E/M pipeline register.
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input logic             clk,
  input logic             rst,
  y86_execute_stage_if.slave bus
);

  localparam logic [W-1:0] STEP_POS = W'(STACK_STEP);
  localparam logic [W-1:0] STEP_NEG = '0 - STEP_POS;

  logic         r_e_valid;
  logic [1:0]   r_e_stat;
  logic [3:0]   r_e_icode;
  logic         r_e_cnd;
  logic [W-1:0] r_e_valE;
  logic [W-1:0] r_e_valA;
  logic [3:0]   r_e_dstE;
  logic [3:0]   r_e_dstM;
  cc_t          r_cc;

  logic         w_accept;
  logic         w_is_opq;
  logic         w_opq_ok;
  logic         w_is_cond;
  logic         w_cond_cnd;
  logic         w_cond_illegal;
  logic         w_cnd;
  logic         w_cc_we;
  logic         w_of;
  logic         w_unused_car;
  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [3:0]   w_alu_fn;
  logic [1:0]   w_stat;
  logic [3:0]   w_dstE;
  cc_t          w_cc_next;

  assign bus.d_ready = ~r_e_valid | bus.e_ready;
  assign w_accept    = bus.d_valid & bus.d_ready;

  // OPq swaps operands so that subq computes valB - valA.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_fn = ALU_ADD;
    case (bus.d_icode)
      I_RRMOVQ: w_alu_a = bus.d_valA;
      I_IRMOVQ: w_alu_a = bus.d_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_alu_a = bus.d_valC;
        w_alu_b = bus.d_valB;
      end
      I_OPQ: begin
        w_alu_a  = bus.d_valB;
        w_alu_b  = bus.d_valA;
        w_alu_fn = opq_alu_fn(bus.d_ifun);
      end
      I_CALL, I_PUSHQ: begin
        w_alu_a = bus.d_valB;
        w_alu_b = STEP_NEG;
      end
      I_RET, I_POPQ: begin
        w_alu_a = bus.d_valB;
        w_alu_b = STEP_POS;
      end
      I_HALT, I_NOP, I_JXX: w_alu_a = '0;
      default:              w_alu_a = '0;
    endcase
  end

  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;
  assign bus.alu_fn = w_alu_fn;

  y86_cond_eval u_cond_eval (
    .i_cc      (r_cc),
    .i_ifun    (bus.d_ifun),
    .o_cnd     (w_cond_cnd),
    .o_illegal (w_cond_illegal)
  );

  assign w_is_opq  = (bus.d_icode == I_OPQ);
  assign w_opq_ok  = opq_legal(bus.d_ifun);
  assign w_is_cond = (bus.d_icode == I_RRMOVQ) | (bus.d_icode == I_JXX);
  assign w_cnd     = w_is_cond & w_cond_cnd;

  // An incoming fault status always wins over a locally detected one.
  always_comb begin
    w_stat = S_AOK;
    if (bus.d_stat != S_AOK)
      w_stat = bus.d_stat;
    else if ((w_is_opq & ~w_opq_ok) | (w_is_cond & w_cond_illegal))
      w_stat = S_INS;
  end

  assign w_dstE = ((bus.d_icode == I_RRMOVQ) & ~w_cnd) ? RNONE : bus.d_dstE;

  always_comb begin
    w_of = 1'b0;
    case (w_alu_fn)
      ALU_ADD: w_of = (w_alu_a[W-1] == w_alu_b[W-1]) &&
                      (bus.alu_valE[W-1] != w_alu_a[W-1]);
      ALU_SUB: w_of = (w_alu_a[W-1] != w_alu_b[W-1]) &&
                      (bus.alu_valE[W-1] != w_alu_a[W-1]);
      default: w_of = 1'b0;
    endcase
  end

  assign w_cc_next = '{zf: (bus.alu_valE == '0), sf: bus.alu_valE[W-1], of: w_of};
  assign w_cc_we   = w_accept & w_is_opq & w_opq_ok &
                     (bus.d_stat == S_AOK) & ~bus.m_exc;

  // Carry is informational only; the CC register keeps ZF/SF/OF.
  assign w_unused_car = bus.alu_car;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_stat  <= S_AOK;
      r_e_icode <= 4'h0;
      r_e_cnd   <= 1'b0;
      r_e_valE  <= '0;
      r_e_valA  <= '0;
      r_e_dstE  <= RNONE;
      r_e_dstM  <= RNONE;
      r_cc      <= CC_RESET;
    end else begin
      if (w_accept) begin
        r_e_valid <= 1'b1;
        r_e_stat  <= w_stat;
        r_e_icode <= bus.d_icode;
        r_e_cnd   <= w_cnd;
        r_e_valE  <= bus.alu_valE;
        r_e_valA  <= bus.d_valA;
        r_e_dstE  <= w_dstE;
        r_e_dstM  <= bus.d_dstM;
      end else if (bus.e_ready) begin
        r_e_valid <= 1'b0;
      end
      if (w_cc_we)
        r_cc <= w_cc_next;
    end
  end

  assign bus.e_valid = r_e_valid;
  assign bus.e_stat  = r_e_stat;
  assign bus.e_icode = r_e_icode;
  assign bus.e_cnd   = r_e_cnd;
  assign bus.e_valE  = r_e_valE;
  assign bus.e_valA  = r_e_valA;
  assign bus.e_dstE  = r_e_dstE;
  assign bus.e_dstM  = r_e_dstM;
  assign bus.cc      = r_cc;

endmodule
